// File: rtl/pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_scan_ctrl
//
// Purpose:
//   Word-level scan controller wrapped around a programmable serial pattern
//   detector. A parallel word is accepted through a start/busy/done handshake.
//   The word is shifted out MSB-first, one bit per clock, into the embedded
//   detector. Matches are counted in either overlapping or non-overlapping
//   mode. The position of the first match is also recorded.
//
// Parameters:
//   WIDTH    bits per scanned word (>= PLEN)
//   PLEN     pattern length in bits (2..8)
//   PATTERN  target pattern; its MSB lines up with the earliest received bit
//   CW       width of count / first_pos
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-low reset
//   start      in   1      scan request, sampled only while idle
//   word       in   WIDTH  word to scan, captured with an accepted start
//   overlap    in   1      1 = overlapping matches, captured with start
//   busy       out  1      high from acceptance through the done cycle
//   done       out  1      one-cycle pulse, results valid
//   hit        out  1      one-cycle pulse one cycle after a match-completing bit
//   found      out  1      at least one match in the last scan
//   count      out  CW     number of matches in the last scan
//   first_pos  out  CW     index (0 = MSB) of the last bit of the first match
// -----------------------------------------------------------------------------
module pattern_scan_ctrl #(
   parameter int                WIDTH   = 16,
   parameter int                PLEN    = 4,
   parameter logic [PLEN-1:0]   PATTERN = 4'b1010,
   parameter int                CW      = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] word,
   input  logic             overlap,
   output logic             busy,
   output logic             done,
   output logic             hit,
   output logic             found,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    first_pos
);

   // Valid-bit counter only needs to reach PLEN, where it saturates.
   localparam int            VW       = $clog2(PLEN+1);
   localparam logic [VW-1:0] PLEN_V   = VW'(PLEN);
   localparam logic [VW-1:0] PLEN_M1  = VW'(PLEN-1);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH-1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t              state_q,  state_d;
   logic [WIDTH-1:0]    shreg_q,  shreg_d;
   logic                ovl_q,    ovl_d;
   logic [PLEN-2:0]     hist_q,   hist_d;
   logic [VW-1:0]       vcnt_q,   vcnt_d;
   logic [CW-1:0]       idx_q,    idx_d;
   logic [CW-1:0]       count_q,  count_d;
   logic                found_q,  found_d;
   logic [CW-1:0]       fpos_q,   fpos_d;
   logic                hit_q,    hit_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;

   // Detector datapath for the current bit
   logic                b;
   logic [PLEN-1:0]     win;
   logic                match;
   logic [VW-1:0]       vcnt_inc;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         ovl_q   <= 1'b0;
         hist_q  <= '0;
         vcnt_q  <= '0;
         idx_q   <= '0;
         count_q <= '0;
         found_q <= 1'b0;
         fpos_q  <= '0;
         hit_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         vcnt_q  <= vcnt_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         found_q <= found_d;
         fpos_q  <= fpos_d;
         hit_q   <= hit_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      ovl_d   = ovl_q;
      hist_d  = hist_q;
      vcnt_d  = vcnt_q;
      idx_d   = idx_q;
      count_d = count_q;
      found_d = found_q;
      fpos_d  = fpos_q;
      hit_d   = 1'b0;

      // Bit under test is always the shift register MSB; the window is the
      // last PLEN-1 retained bits followed by this one.
      b        = shreg_q[WIDTH-1];
      win      = {hist_q, b};
      vcnt_inc = (vcnt_q == PLEN_V) ? vcnt_q : vcnt_q + VW'(1);
      // vcnt_q counts bits already in the history, so PLEN-1 of them plus
      // the current bit make a full window.
      match    = (state_q == S_SCAN) && (win == PATTERN) && (vcnt_q >= PLEN_M1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               shreg_d = word;
               ovl_d   = overlap;
               hist_d  = '0;
               vcnt_d  = '0;
               idx_d   = '0;
               count_d = '0;
               found_d = 1'b0;
               fpos_d  = '0;
               state_d = S_SCAN;
            end
         end

         S_SCAN: begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            idx_d   = idx_q + CW'(1);
            hist_d  = win[PLEN-2:0];
            vcnt_d  = vcnt_inc;
            if (match) begin
               count_d = count_q + CW'(1);
               hit_d   = 1'b1;
               if (!found_q) begin
                  found_d = 1'b1;
                  fpos_d  = idx_q;
               end
               // Non-overlapping: forget the matched bits so the next match
               // must be built entirely from fresh input.
               if (!ovl_q) begin
                  hist_d = '0;
                  vcnt_d = '0;
               end
            end
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Handshake outputs are registered copies of the upcoming state so that
      // busy/done line up with the state they describe.
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // ---------------------------------------------------------------------------
   // Outputs (all registered)
   // ---------------------------------------------------------------------------
   assign busy      = busy_q;
   assign done      = done_q;
   assign hit       = hit_q;
   assign found     = found_q;
   assign count     = count_q;
   assign first_pos = fpos_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
module tb_pattern_scan_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] word;
   logic        overlap;
   logic        busy;
   logic        done;
   logic        hit;
   logic        found;
   logic [4:0]  count;
   logic [4:0]  first_pos;

   int checks;
   int errors;

   pattern_scan_ctrl #(
      .WIDTH   (16),
      .PLEN    (4),
      .PATTERN (4'b1010)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .word      (word),
      .overlap   (overlap),
      .busy      (busy),
      .done      (done),
      .hit       (hit),
      .found     (found),
      .count     (count),
      .first_pos (first_pos)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle; inputs are driven and outputs
   // sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      word = '0;
      overlap = 1'b0;
      tick();
      tick();
      checks++;
      if ({busy, done, hit, found, count, first_pos} !== 14'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b hit=%b found=%b count=%0d pos=%0d want all 0",
                  busy, done, hit, found, count, first_pos);
      end
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy[%0d]: got %b want 0", i, busy);
         end
      end
   endtask

   // Full scan with per-bit hit/count/done checks and final result checks.
   // hmask bit i = expected hit for bit index i (0 = MSB of word).
   task automatic run_scan(input string name, input logic [15:0] w, input logic ovl,
                           input logic [15:0] hmask, input int ecount,
                           input logic efound, input int epos);
      int run;
      run = 0;
      start = 1'b1;
      word = w;
      overlap = ovl;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: got busy=%b done=%b want busy=1 done=0", name, busy, done);
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         if (hmask[i]) run++;
         checks++;
         if (hit !== hmask[i]) begin
            errors++;
            $display("FAIL %s hit[%0d]: got %b want %b", name, i, hit, hmask[i]);
         end
         checks++;
         if (count !== 5'(run)) begin
            errors++;
            $display("FAIL %s count[%0d]: got %0d want %0d", name, i, count, run);
         end
         checks++;
         if (done !== (i == 15) || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done[%0d]: got done=%b busy=%b want done=%b busy=1",
                     name, i, done, busy, (i == 15));
         end
      end
      checks++;
      if (count !== 5'(ecount) || found !== efound || first_pos !== 5'(epos)) begin
         errors++;
         $display("FAIL %s result: got count=%0d found=%b pos=%0d want count=%0d found=%b pos=%0d",
                  name, count, found, first_pos, ecount, efound, epos);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || count !== 5'(ecount) || found !== efound ||
          first_pos !== 5'(epos)) begin
         errors++;
         $display("FAIL %s hold: got done=%b busy=%b count=%0d found=%b pos=%0d want 0 0 %0d %b %0d",
                  name, done, busy, count, found, first_pos, ecount, efound, epos);
      end
   endtask

   task automatic test_overlap();
      // hits at bit indices 3,5,...,15
      run_scan("ovl_AAAA", 16'hAAAA, 1'b1, 16'hAAA8, 7, 1'b1, 3);
   endtask

   task automatic test_nonoverlap();
      // hits at bit indices 3,7,11,15
      run_scan("novl_AAAA", 16'hAAAA, 1'b0, 16'h8888, 4, 1'b1, 3);
   endtask

   task automatic test_boundary();
      run_scan("last_bit_000A", 16'h000A, 1'b1, 16'h8000, 1, 1'b1, 15);
      run_scan("zero_word", 16'h0000, 1'b1, 16'h0000, 0, 1'b0, 0);
      // partial pattern 101 at the end must not count
      run_scan("partial_0005", 16'h0005, 1'b0, 16'h0000, 0, 1'b0, 0);
   endtask

   task automatic test_handshake();
      int hits;
      hits = 0;
      start = 1'b1;
      word = 16'hAAAA;
      overlap = 1'b1;
      tick();                                   // edge k
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 2) begin                      // start high at edge k+3
            start = 1'b1;
            word = 16'hFFFF;
            overlap = 1'b0;
         end
         tick();
         start = 1'b0;
         if (hit === 1'b1) hits++;
      end
      checks++;
      if (hits != 7 || count !== 5'd7 || done !== 1'b1 || first_pos !== 5'd3) begin
         errors++;
         $display("FAIL hs_scan: got hits=%0d count=%0d done=%b pos=%0d want 7 7 1 3",
                  hits, count, done, first_pos);
      end
      start = 1'b1;                             // start at edge k+WIDTH+1
      word = 16'hFFFF;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || count !== 5'd7) begin
         errors++;
         $display("FAIL hs_ignore_done: got busy=%b done=%b count=%0d want 0 0 7",
                  busy, done, count);
      end
      word = 16'h000A;                          // start at edge k+WIDTH+2
      overlap = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || count !== 5'd0) begin
         errors++;
         $display("FAIL hs_accept: got busy=%b count=%0d want 1 0", busy, count);
      end
      for (int i = 0; i < 16; i++) tick();
      checks++;
      if (done !== 1'b1 || count !== 5'd1 || first_pos !== 5'd15) begin
         errors++;
         $display("FAIL hs_second_scan: got done=%b count=%0d pos=%0d want 1 1 15",
                  done, count, first_pos);
      end
      tick();
   endtask

   task automatic test_reset_midscan();
      int done_seen;
      done_seen = 0;
      start = 1'b1;
      word = 16'hAAAA;
      overlap = 1'b1;
      tick();                                   // edge k
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();       // edges k+1..k+5, match at bit 3
      reset = 1'b0;
      tick();                                   // edge k+6
      checks++;
      if ({busy, done, hit, found, count, first_pos} !== 14'd0) begin
         errors++;
         $display("FAIL midscan_reset: got busy=%b done=%b hit=%b found=%b count=%0d pos=%0d want all 0",
                  busy, done, hit, found, count, first_pos);
      end
      tick();
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         errors++;
         $display("FAIL midscan_no_done: got %0d busy/done cycles want 0", done_seen);
      end
      run_scan("post_reset", 16'hAAAA, 1'b1, 16'hAAA8, 7, 1'b1, 3);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      start = 1'b0;
      word = '0;
      overlap = 1'b0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_boundary();
      test_handshake();
      test_reset_midscan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
